falu_sequencer: RTL and testbench



---
 rtl/falu_pkg.sv | 24 ++
 rtl/falu_sequencer_if.sv | 31 +++
 rtl/falu_watchdog.sv | 29 ++
 rtl/falu_sequencer.sv | 137 +++++++++++++
 tb/tb_falu_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/falu_pkg.sv
// Shared types and constants for the FALU issue sequencer.
// The optional watchdog is compiled in with FALU_TIMEOUT_EN.
package falu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } falu_seq_state_t;

  localparam logic FALU_OP_ADD = 1'b0;
  localparam logic FALU_OP_SUB = 1'b1;

  localparam logic [6:0] OPCODE_FP = 7'b1010011;
  localparam logic [6:0] FADD_S    = 7'b0000000;
  localparam logic [6:0] FSUB_S    = 7'b0000100;

  // Maps an OP-FP funct7 to the sequencer op bit (SUB only for FSUB.S).
  function automatic logic funct7_to_op(input logic [6:0] funct7);
    return (funct7 == FSUB_S) ? FALU_OP_SUB : FALU_OP_ADD;
  endfunction

endpackage

// File: rtl/falu_sequencer_if.sv
// FALU start/done bus and register-file writeback handshake.
// master = sequencer side, slave = FALU plus writeback arbiter side.
interface falu_sequencer_if #(
  parameter int FLEN = 32
);
  logic            falu_start;
  logic            falu_op;
  logic [FLEN-1:0] falu_a;
  logic [FLEN-1:0] falu_b;
  logic            falu_done;
  logic [FLEN-1:0] falu_result;

  logic            wb_valid;
  logic            wb_ready;
  logic [4:0]      wb_rd;
  logic [FLEN-1:0] wb_data;

  modport master (
    output falu_start, falu_op, falu_a, falu_b,
    input  falu_done, falu_result,
    output wb_valid, wb_rd, wb_data,
    input  wb_ready
  );

  modport slave (
    input  falu_start, falu_op, falu_a, falu_b,
    output falu_done, falu_result,
    input  wb_valid, wb_rd, wb_data,
    output wb_ready
  );
endinterface

// File: rtl/falu_watchdog.sv
// Cycle counter that flags a FALU that never reports done.
// Only instantiated when FALU_TIMEOUT_EN is defined.
module falu_watchdog #(
  parameter int MAX_LAT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic active,
  input  logic done,
  output logic expired
);
  localparam int CW = $clog2(MAX_LAT + 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (active) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  // Fires on the edge where the count would reach MAX_LAT, unless done arrives.
  assign expired = active && !done && (count_reg == CW'(MAX_LAT - 1));
endmodule

// File: rtl/falu_sequencer.sv
// Multi-cycle FADD.S/FSUB.S issue sequencer: stalls the pipeline, drives the FALU,
// hands the result to writeback. Define FALU_TIMEOUT_EN to add the watchdog.
module falu_sequencer
  import falu_pkg::*;
#(
  parameter int FLEN    = 32,
  parameter int MAX_LAT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  input  logic            issue_op,
  input  logic [FLEN-1:0] issue_a,
  input  logic [FLEN-1:0] issue_b,
  input  logic [4:0]      issue_rd,
  input  logic            flush,
  output logic            stall,
  output logic            err,
  falu_sequencer_if.master bus
);

  if (MAX_LAT < 1) begin : g_lat_check
    $error("falu_sequencer: MAX_LAT must be at least 1");
  end

  falu_seq_state_t state_reg;
  logic            start_reg;
  logic            op_reg;
  logic [FLEN-1:0] a_reg;
  logic [FLEN-1:0] b_reg;
  logic [4:0]      rd_reg;
  logic            wb_valid_reg;
  logic [FLEN-1:0] wb_data_reg;
  logic            timeout;

`ifdef FALU_TIMEOUT_EN
  logic err_reg;

  falu_watchdog #(
    .MAX_LAT(MAX_LAT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_reg == IDLE),
    .active  ((state_reg == WAIT) || (state_reg == DRAIN)),
    .done    (bus.falu_done),
    .expired (timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= timeout;
    end
  end

  assign err = err_reg;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      start_reg    <= 1'b0;
      op_reg       <= 1'b0;
      a_reg        <= '0;
      b_reg        <= '0;
      rd_reg       <= '0;
      wb_valid_reg <= 1'b0;
      wb_data_reg  <= '0;
    end else begin
      start_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (issue_valid && !flush) begin
            op_reg    <= issue_op;
            a_reg     <= issue_a;
            b_reg     <= issue_b;
            rd_reg    <= issue_rd;
            start_reg <= 1'b1;
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (timeout) begin
            state_reg <= IDLE;
          end else if (bus.falu_done && !flush) begin
            wb_data_reg  <= bus.falu_result;
            wb_valid_reg <= 1'b1;
            state_reg    <= HOLD;
          end else if (bus.falu_done) begin
            state_reg <= IDLE;
          end else if (flush) begin
            // The FALU cannot be aborted, so its pending result must be swallowed.
            state_reg <= DRAIN;
          end
        end
        HOLD: begin
          if (flush || bus.wb_ready) begin
            wb_valid_reg <= 1'b0;
            state_reg    <= IDLE;
          end
        end
        DRAIN: begin
          if (timeout || bus.falu_done) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Released in the accepting HOLD cycle so EX advances past the finished op.
  always_comb begin
    stall = 1'b0;
    case (state_reg)
      IDLE:    stall = issue_valid && !flush;
      WAIT:    stall = 1'b1;
      HOLD:    stall = !bus.wb_ready;
      DRAIN:   stall = issue_valid;
      default: stall = 1'b0;
    endcase
  end

  assign bus.falu_start = start_reg;
  assign bus.falu_op    = op_reg;
  assign bus.falu_a     = a_reg;
  assign bus.falu_b     = b_reg;
  assign bus.wb_valid   = wb_valid_reg;
  assign bus.wb_rd      = rd_reg;
  assign bus.wb_data    = wb_data_reg;

endmodule

// File: tb/tb_falu_sequencer.sv
// Randomised bench for falu_sequencer: a FALU responder, a writeback scoreboard
// and a per-cycle timeline model of stall/start/valid for each transaction.
module tb_falu_sequencer;
  localparam int FLEN    = 32;
  localparam int MAX_LAT = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            issue_valid;
  logic            issue_op;
  logic [FLEN-1:0] issue_a;
  logic [FLEN-1:0] issue_b;
  logic [4:0]      issue_rd;
  logic            flush;
  logic            stall;
  logic            err;

  falu_sequencer_if #(.FLEN(FLEN)) bus ();

  falu_sequencer #(
    .FLEN    (FLEN),
    .MAX_LAT (MAX_LAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_op    (issue_op),
    .issue_a     (issue_a),
    .issue_b     (issue_b),
    .issue_rd    (issue_rd),
    .flush       (flush),
    .stall       (stall),
    .err         (err),
    .bus         (bus.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;
  wb_t exp_q[$];
  wb_t mon_e;

  int          falu_lat   = 0;
  bit          falu_hang  = 1'b0;
  bit          use_forced = 1'b0;
  logic [31:0] forced     = '0;
  logic [31:0] rsp_r;
  int          rsp_l;

  // Stand-in arithmetic for the FALU; only the data path through the sequencer matters.
  function automatic logic [31:0] fmodel(input logic op, input logic [31:0] a, input logic [31:0] b);
    return op ? (a - b) : (a + b);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // FALU responder: done arrives falu_lat cycles after the start cycle.
  initial begin
    bus.falu_done   = 1'b0;
    bus.falu_result = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.falu_start && rst_n && !falu_hang) begin
        rsp_r = use_forced ? forced : fmodel(bus.falu_op, bus.falu_a, bus.falu_b);
        rsp_l = falu_lat;
        repeat (rsp_l) begin
          @(posedge clk); #1;
        end
        bus.falu_done   = 1'b1;
        bus.falu_result = rsp_r;
        @(posedge clk); #1;
        bus.falu_done   = 1'b0;
      end
    end
  end

  // Writeback monitor: every accepted handshake pops one expected result.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.wb_valid && bus.wb_ready && !flush) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL wb_unexpected: got rd=%0d data=%h expected no writeback", bus.wb_rd, bus.wb_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("wb_rd", 32'(bus.wb_rd), 32'(mon_e.rd));
          check("wb_data", bus.wb_data, mon_e.data);
          $display("writeback rd=%0d data=%h", bus.wb_rd, bus.wb_data);
        end
      end
    end
  end

  // mode: 0 normal, 1 flush in WAIT at cycle f, 2 flush with done,
  //       3 flush with wb_ready in HOLD, 4 flush in HOLD without wb_ready.
  // Cycle t=0 is the issue cycle; the FALU answers in cycle d=lat+1.
  task automatic run_txn(input logic op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int lat, input int w,
                         input int mode, input int f, input bit drain_iv);
    int d, e, last;
    logic [31:0] expd;
    bit iv, fl, rdy, ex_stall, ex_wbv, has_wb;
    d    = lat + 1;
    e    = d + 1 + w;
    expd = use_forced ? forced : fmodel(op, a, b);
    has_wb = (mode == 0) || (mode == 3) || (mode == 4);
    last = has_wb ? e : d;
    falu_lat = lat;
    if (mode == 0) exp_q.push_back('{rd, expd});
    for (int t = 0; t <= last; t++) begin
      iv  = 1'b1;
      fl  = 1'b0;
      rdy = 1'b0;
      if (mode == 1 && t >= f) iv = (t > f) && drain_iv;
      if (mode == 1 && t == f) fl = 1'b1;
      if (mode == 2 && t == d) begin fl = 1'b1; iv = 1'b0; end
      if (has_wb && t == e) rdy = (mode != 4);
      if ((mode == 3 || mode == 4) && t == e) begin fl = 1'b1; iv = 1'b0; end
      issue_valid  = iv;
      issue_op     = op;
      issue_a      = a;
      issue_b      = b;
      issue_rd     = rd;
      flush        = fl;
      bus.wb_ready = rdy;

      if (t == 0)                       ex_stall = 1'b1;
      else if (t <= d)                  ex_stall = (mode == 1 && t > f) ? drain_iv : 1'b1;
      else                              ex_stall = !rdy;
      ex_wbv = has_wb && (t >= d + 1);

      @(negedge clk);
      check($sformatf("stall_t%0d_m%0d", t, mode), 32'(stall), 32'(ex_stall));
      check($sformatf("falu_start_t%0d", t), 32'(bus.falu_start), 32'(t == 1));
      check($sformatf("wb_valid_t%0d_m%0d", t, mode), 32'(bus.wb_valid), 32'(ex_wbv));
      check("err_idle", 32'(err), 32'd0);
      if (t == 1) begin
        check("falu_a", bus.falu_a, a);
        check("falu_b", bus.falu_b, b);
        check("falu_op", 32'(bus.falu_op), 32'(op));
      end
      if (ex_wbv) begin
        check("hold_wb_rd", 32'(bus.wb_rd), 32'(rd));
        check("hold_wb_data", bus.wb_data, expd);
      end
      @(posedge clk); #1;
    end
    issue_valid  = 1'b0;
    flush        = 1'b0;
    bus.wb_ready = 1'b0;
    $display("txn op=%0d a=%h b=%h rd=%0d lat=%0d wait=%0d mode=%0d", op, a, b, rd, lat, w, mode);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_stall"},      32'(stall), 32'd0);
    check({tag, "_err"},        32'(err), 32'd0);
    check({tag, "_falu_start"}, 32'(bus.falu_start), 32'd0);
    check({tag, "_falu_op"},    32'(bus.falu_op), 32'd0);
    check({tag, "_falu_a"},     bus.falu_a, 32'd0);
    check({tag, "_falu_b"},     bus.falu_b, 32'd0);
    check({tag, "_wb_valid"},   32'(bus.wb_valid), 32'd0);
    check({tag, "_wb_rd"},      32'(bus.wb_rd), 32'd0);
    check({tag, "_wb_data"},    bus.wb_data, 32'd0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    issue_valid = 1'b0;
    flush = 1'b0;
    bus.wb_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int mode, lat, f;
    rst_n        = 1'b1;
    issue_valid  = 1'b0;
    issue_op     = 1'b0;
    issue_a      = '0;
    issue_b      = '0;
    issue_rd     = '0;
    flush        = 1'b0;
    bus.wb_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_values("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic FADD: 1.0 + 2.0, done three cycles after start.
    use_forced = 1'b1;
    forced     = 32'h4040_0000;
    run_txn(1'b0, 32'h3F80_0000, 32'h4000_0000, 5'd5, 3, 0, 0, 0, 1'b0);
    use_forced = 1'b0;

    // Writeback backpressure for four cycles.
    run_txn(1'b1, $urandom, $urandom, 5'd17, 2, 4, 0, 0, 1'b0);
    // Flush one cycle after start, done five cycles after that, new issue waiting in DRAIN.
    run_txn(1'b0, $urandom, $urandom, 5'd9, 6, 0, 1, 2, 1'b1);
    run_txn(1'b1, $urandom, $urandom, 5'd3, 2, 0, 2, 0, 1'b0);
    run_txn(1'b0, $urandom, $urandom, 5'd4, 1, 2, 3, 0, 1'b0);
    run_txn(1'b1, $urandom, $urandom, 5'd6, 0, 1, 4, 0, 1'b0);
    run_txn(1'b0, $urandom, $urandom, 5'd31, 0, 0, 0, 0, 1'b0);

    // issue_valid together with flush in IDLE is ignored.
    issue_valid = 1'b1;
    flush       = 1'b1;
    issue_a     = 32'h1234_5678;
    @(negedge clk);
    check("idle_flush_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    issue_valid = 1'b0;
    flush       = 1'b0;
    @(negedge clk);
    check("idle_flush_no_start", 32'(bus.falu_start), 32'd0);
    check("idle_flush_stall2", 32'(stall), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 5);
      if (mode == 5) mode = 0;
      lat = (mode == 1) ? $urandom_range(1, 5) : $urandom_range(0, 5);
      f   = (mode == 1) ? $urandom_range(1, lat) : 0;
      run_txn(1'($urandom), $urandom, $urandom, 5'($urandom), lat,
              $urandom_range(0, 3), mode, f, 1'($urandom));
    end

    // Reset during WAIT: outputs clear at once, the late done is ignored.
    falu_lat    = 6;
    issue_valid = 1'b1;
    issue_op    = 1'b1;
    issue_a     = 32'hDEAD_BEEF;
    issue_b     = 32'h0BAD_F00D;
    issue_rd    = 5'd12;
    @(posedge clk); #1;
    issue_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_reset_stall", 32'(stall), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_values("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 8; t++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("postreset_wb_valid", 32'(bus.wb_valid), 32'd0);
      check("postreset_stall", 32'(stall), 32'd0);
      check("postreset_start", 32'(bus.falu_start), 32'd0);
    end
    @(posedge clk); #1;

    // FALU that never answers.
    falu_hang   = 1'b1;
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    for (int t = 0; t <= 24; t++) begin
`ifdef FALU_TIMEOUT_EN
      if (t >= MAX_LAT + 1) issue_valid = 1'b0;
`endif
      @(negedge clk);
      check("hang_wb_valid", 32'(bus.wb_valid), 32'd0);
`ifdef FALU_TIMEOUT_EN
      check($sformatf("wd_err_t%0d", t), 32'(err), 32'(t == MAX_LAT + 1));
      check($sformatf("wd_stall_t%0d", t), 32'(stall), 32'(t <= MAX_LAT));
`else
      check($sformatf("hang_err_t%0d", t), 32'(err), 32'd0);
      check($sformatf("hang_stall_t%0d", t), 32'(stall), 32'd1);
`endif
      @(posedge clk); #1;
    end
    falu_hang = 1'b0;
    pulse_reset();

    run_txn(1'b0, $urandom, $urandom, 5'd1, 1, 1, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish before 200000");
    $fatal(1, "bench time limit");
  end

endmodule
